zeroriscy_fetch_aligner: RTL and testbench
==========================================

Name: zeroriscy_fetch_aligner

Overview:
Sits directly downstream of the prefetch buffer's output port (valid/ready/rdata/addr) and upstream of the IF-stage instruction register and compressed decoder.
- Input is a stream of word-aligned 32-bit fetch words.
- Output is one instruction per handshake, either a full RV32 instruction or a 16-bit RVC instruction zero-extended, each with its exact PC.
- Handles 32-bit instructions that straddle two fetch words.
- Handles branch targets at halfword offsets (addr[1]=1).

Parameters:
None. The datapath is fixed at 32 bits and the holding register at one halfword.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
branch_i  in  1  flush; a new fetch stream starts at branch_addr_i
branch_addr_i  in  32  branch target; only bit 1 is used here
in_valid_i  in  1  fetch word valid (from prefetch buffer valid_o)
in_ready_o  out  1  fetch word consumed this cycle (to prefetch buffer ready_i)
in_rdata_i  in  32  fetch word
in_addr_i  in  32  fetch word address; bits [1:0] are ignored and treated as 00
out_valid_o  out  1  aligned instruction valid
out_ready_i  in  1  IF stage accepts the instruction
out_instr_o  out  32  instruction; RVC is zero-extended to 32 bits
out_pc_o  out  32  PC of out_instr_o
out_is_compressed_o  out  1  out_instr_o[1:0] != 2'b11
busy_o  out  1  state != ALIGNED

Behaviour:
- RVC detect: a halfword h is compressed iff h[1:0] != 2'b11.
- State registers:
  - state_q is one of {ALIGNED, UNALIGNED, BRANCH_HALF}.
  - hold_q[15:0] holds a pending upper halfword.
  - hold_pc_q[31:0] holds its PC.
- Reset:
  - state_q=ALIGNED, hold_q=0, hold_pc_q=0.
  - Consequently out_valid_o=0 and busy_o=0, with in_valid_i=0.
- All outputs are combinational from state and inputs. There is no added latency: an instruction appears in the same cycle its last halfword is presented.
- w = in_rdata_i; A = {in_addr_i[31:2],2'b00}.
- ALIGNED:
  - If w[15:0] is RVC:
    - out_valid=in_valid, out_instr={16'h0,w[15:0]}, out_pc=A.
    - in_ready=out_ready.
    - On handshake: hold_q=w[31:16], hold_pc_q=A+2, go to UNALIGNED.
  - Otherwise:
    - out_valid=in_valid, out_instr=w, out_pc=A.
    - in_ready=out_ready.
    - State stays ALIGNED.
- UNALIGNED, hold_q is RVC:
  - out_valid=1 with no input needed, out_instr={16'h0,hold_q}, out_pc=hold_pc_q.
  - in_ready=0.
  - On out_ready: go to ALIGNED.
- UNALIGNED, hold_q is not RVC:
  - out_valid=in_valid, out_instr={w[15:0],hold_q}, out_pc=hold_pc_q.
  - in_ready=out_ready.
  - On handshake: hold_q=w[31:16], hold_pc_q=A+2, state stays UNALIGNED.
- BRANCH_HALF:
  - out_valid=0, in_ready=1.
  - On in_valid: hold_q=w[31:16], hold_pc_q=A+2, go to UNALIGNED.
  - The discarded lower half costs one bubble cycle.
- Branch has priority over every case above:
  - In the cycle branch_i=1: out_valid_o=0 and in_ready_o=0.
  - Next state is BRANCH_HALF if branch_addr_i[1] else ALIGNED.
  - hold_q is not cleared; it is don't-care outside UNALIGNED.
- PC arithmetic is 32-bit modulo; A+2 at 0xFFFF_FFFC yields 0xFFFF_FFFE with no trap.
- Stall: with out_ready_i=0, the outputs and state hold and no word is consumed.
- Empty input: in UNALIGNED with a non-RVC hold and in_valid_i=0, out_valid_o=0. This is the only case where a held halfword waits.
- Reset mid-stream discards hold_q immediately; no partial instruction is emitted.

Decomposition:
- Shared package zeroriscy_pkg:
  - fetch_align_state_e enum (2 bits).
  - Function is_compressed(logic [15:0]).
  - Constant OPCODE_UNCOMPRESSED=2'b11.
- No sub-module; a single module with one always_comb and one always_ff.

Test Plan:
- Reset, then stream words 0x00000013 @0x100 and 0x00100093 @0x104 with out_ready=1 → two 32-bit outputs, pc 0x100 and 0x104, is_compressed=0, in_ready=1 each cycle.
- Word 0x45014501 @0x200 → out 0x00004501 pc 0x200; then 0x00004501 pc 0x202 with in_ready=0; one word consumed for two instructions.
- Word 0x00134501 @0x300, then 0x4501_0000 @0x304 → outputs RVC 0x4501 pc 0x300, then straddling 0x00000013 pc 0x302, then RVC 0x4501 pc 0x306.
- branch_i with branch_addr 0x402, then word 0x0093ABCD @0x400 → one bubble cycle with out_valid=0, state UNALIGNED; the upper half 0x0093 waits for the next word 0x00000000 @0x404 → out 0x00000093 pc 0x402.
- Hold out_ready=0 for 3 cycles while in UNALIGNED with a non-RVC hold and in_valid=1 → outputs stable, in_ready=0, nothing consumed; release → single handshake.
- branch_i asserted in the same cycle as in_valid, in UNALIGNED → out_valid=0, in_ready=0, next state ALIGNED; the following word @target is emitted correctly with pc=target.

Source files
------------

// File: rtl/zeroriscy_pkg.sv
// Shared fetch-alignment types and helpers.
package zeroriscy_pkg;

  typedef enum logic [1:0] {
    FA_ALIGNED     = 2'd0,
    FA_UNALIGNED   = 2'd1,
    FA_BRANCH_HALF = 2'd2
  } fetch_align_state_e;

  localparam logic [1:0] OPCODE_UNCOMPRESSED = 2'b11;

  // A halfword starts an RVC instruction unless its low two bits are 11.
  function automatic logic is_compressed(input logic [15:0] h);
    logic unused_hi;
    unused_hi = ^h[15:2];
    return h[1:0] != OPCODE_UNCOMPRESSED;
  endfunction

endpackage

// File: rtl/zeroriscy_fetch_aligner_if.sv
// Handshake bundle between prefetch buffer, aligner and IF stage.
interface zeroriscy_fetch_aligner_if;

  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_rdata_i;
  logic [31:0] in_addr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_o;
  logic        out_is_compressed_o;
  logic        busy_o;

  // Aligner side.
  modport slave (
    input  branch_i, branch_addr_i, in_valid_i, in_rdata_i, in_addr_i, out_ready_i,
    output in_ready_o, out_valid_o, out_instr_o, out_pc_o, out_is_compressed_o, busy_o
  );

  // Environment side (prefetch buffer + IF stage).
  modport master (
    output branch_i, branch_addr_i, in_valid_i, in_rdata_i, in_addr_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_instr_o, out_pc_o, out_is_compressed_o, busy_o
  );

endinterface

// File: rtl/zeroriscy_fetch_aligner.sv
// Splits word-aligned fetch words into RV32/RVC instructions with exact PCs.
module zeroriscy_fetch_aligner
  import zeroriscy_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  zeroriscy_fetch_aligner_if.slave   bus
);

  fetch_align_state_e state_q, state_d;
  logic [15:0]        hold_q, hold_d;
  logic [31:0]        hold_pc_q, hold_pc_d;

  logic [31:0] w;
  logic [31:0] word_addr;
  logic [31:0] word_addr_hi;
  logic        out_valid;
  logic        in_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        unused_addr_bits;

  assign w            = bus.in_rdata_i;
  assign word_addr    = {bus.in_addr_i[31:2], 2'b00};
  assign word_addr_hi = word_addr + 32'd2;
  assign unused_addr_bits = ^{bus.in_addr_i[1:0], bus.branch_addr_i[31:2], bus.branch_addr_i[0]};

  // Next-state, hold register update and all handshake/instruction outputs.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    hold_pc_d = hold_pc_q;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    out_instr = w;
    out_pc    = word_addr;

    if (bus.branch_i) begin
      state_d = bus.branch_addr_i[1] ? FA_BRANCH_HALF : FA_ALIGNED;
    end else begin
      unique case (state_q)
        FA_ALIGNED: begin
          out_valid = bus.in_valid_i;
          in_ready  = bus.out_ready_i;
          out_pc    = word_addr;
          if (is_compressed(w[15:0])) begin
            out_instr = {16'h0000, w[15:0]};
            if (bus.in_valid_i && bus.out_ready_i) begin
              hold_d    = w[31:16];
              hold_pc_d = word_addr_hi;
              state_d   = FA_UNALIGNED;
            end
          end else begin
            out_instr = w;
          end
        end
        FA_UNALIGNED: begin
          out_pc = hold_pc_q;
          if (is_compressed(hold_q)) begin
            out_valid = 1'b1;
            in_ready  = 1'b0;
            out_instr = {16'h0000, hold_q};
            if (bus.out_ready_i) begin
              state_d = FA_ALIGNED;
            end
          end else begin
            out_valid = bus.in_valid_i;
            in_ready  = bus.out_ready_i;
            out_instr = {w[15:0], hold_q};
            if (bus.in_valid_i && bus.out_ready_i) begin
              hold_d    = w[31:16];
              hold_pc_d = word_addr_hi;
            end
          end
        end
        FA_BRANCH_HALF: begin
          out_valid = 1'b0;
          in_ready  = 1'b1;
          if (bus.in_valid_i) begin
            hold_d    = w[31:16];
            hold_pc_d = word_addr_hi;
            state_d   = FA_UNALIGNED;
          end
        end
        default: begin
          state_d = FA_ALIGNED;
        end
      endcase
    end
  end

  assign bus.out_valid_o         = out_valid;
  assign bus.in_ready_o          = in_ready;
  assign bus.out_instr_o         = out_instr;
  assign bus.out_pc_o            = out_pc;
  assign bus.out_is_compressed_o = (out_instr[1:0] != OPCODE_UNCOMPRESSED);
  assign bus.busy_o              = (state_q != FA_ALIGNED);

  // State and pending-halfword registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FA_ALIGNED;
      hold_q    <= '0;
      hold_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      hold_pc_q <= hold_pc_d;
    end
  end

endmodule

// File: tb/tb_zeroriscy_fetch_aligner.sv
// Directed self-checking bench for the fetch aligner.
module tb_zeroriscy_fetch_aligner;

  logic clk;
  logic rst_n;
  int unsigned checks;
  int unsigned errors;

  zeroriscy_fetch_aligner_if bus ();

  zeroriscy_fetch_aligner dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic br, input logic [31:0] baddr, input logic v,
                       input logic [31:0] data, input logic [31:0] addr, input logic ordy);
    bus.branch_i      = br;
    bus.branch_addr_i = baddr;
    bus.in_valid_i    = v;
    bus.in_rdata_i    = data;
    bus.in_addr_i     = addr;
    bus.out_ready_i   = ordy;
  endtask

  // Checks valid/ready/busy always; instruction, PC and RVC flag only when valid is expected.
  task automatic chk_out(input string tag, input logic v, input logic [31:0] instr,
                         input logic [31:0] pc, input logic rdy, input logic busy);
    chk({tag, ".valid"}, {31'd0, bus.out_valid_o}, {31'd0, v});
    chk({tag, ".ready"}, {31'd0, bus.in_ready_o}, {31'd0, rdy});
    chk({tag, ".busy"}, {31'd0, bus.busy_o}, {31'd0, busy});
    if (v) begin
      chk({tag, ".instr"}, bus.out_instr_o, instr);
      chk({tag, ".pc"}, bus.out_pc_o, pc);
      chk({tag, ".rvc"}, {31'd0, bus.out_is_compressed_o}, {31'd0, (instr[1:0] != 2'b11)});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    #1 chk_out("reset", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two aligned 32-bit instructions; address low bits ignored on the second.
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0013, 32'h0000_0100, 1'b1);
    #1 chk_out("a32_0", 1'b1, 32'h0000_0013, 32'h0000_0100, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h0010_0093, 32'h0000_0107, 1'b1);
    #1 chk_out("a32_1", 1'b1, 32'h0010_0093, 32'h0000_0104, 1'b1, 1'b0);
    @(negedge clk);

    // Two RVC in one word: second needs no input.
    drive(1'b0, 32'h0, 1'b1, 32'h4501_4501, 32'h0000_0200, 1'b1);
    #1 chk_out("rvc2_0", 1'b1, 32'h0000_4501, 32'h0000_0200, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0204, 1'b1);
    #1 chk_out("rvc2_1", 1'b1, 32'h0000_4501, 32'h0000_0202, 1'b0, 1'b1);
    @(negedge clk);

    // RVC, straddling 32-bit, RVC.
    drive(1'b0, 32'h0, 1'b1, 32'h0013_4501, 32'h0000_0300, 1'b1);
    #1 chk_out("str_0", 1'b1, 32'h0000_4501, 32'h0000_0300, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h4501_0000, 32'h0000_0304, 1'b1);
    #1 chk_out("str_1", 1'b1, 32'h0000_0013, 32'h0000_0302, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1 chk_out("str_2", 1'b1, 32'h0000_4501, 32'h0000_0306, 1'b0, 1'b1);
    @(negedge clk);

    // Branch to halfword target.
    drive(1'b1, 32'h0000_0402, 1'b0, 32'h0, 32'h0, 1'b1);
    #1 chk_out("br_0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h0093_ABCD, 32'h0000_0400, 1'b1);
    #1 chk_out("br_bubble", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1 chk_out("br_empty", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0000, 32'h0000_0404, 1'b1);
    #1 chk_out("br_str", 1'b1, 32'h0000_0093, 32'h0000_0402, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1 chk_out("br_rvc0", 1'b1, 32'h0000_0000, 32'h0000_0406, 1'b0, 1'b1);
    @(negedge clk);

    // Stall with non-RVC hold and valid input.
    drive(1'b0, 32'h0, 1'b1, 32'h0093_4501, 32'h0000_0500, 1'b1);
    #1 chk_out("st_pre", 1'b1, 32'h0000_4501, 32'h0000_0500, 1'b1, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 32'h4501_0000, 32'h0000_0504, 1'b0);
      #1 chk_out($sformatf("stall%0d", i), 1'b1, 32'h0000_0093, 32'h0000_0502, 1'b0, 1'b1);
      @(negedge clk);
    end
    drive(1'b0, 32'h0, 1'b1, 32'h4501_0000, 32'h0000_0504, 1'b1);
    #1 chk_out("st_rel", 1'b1, 32'h0000_0093, 32'h0000_0502, 1'b1, 1'b1);
    @(negedge clk);

    // Branch while UNALIGNED with valid input, to an aligned target.
    drive(1'b1, 32'h0000_0600, 1'b1, 32'h4501_0000, 32'h0000_0504, 1'b1);
    #1 chk_out("br_un", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h0010_0093, 32'h0000_0600, 1'b1);
    #1 chk_out("br_tgt", 1'b1, 32'h0010_0093, 32'h0000_0600, 1'b1, 1'b0);
    @(negedge clk);

    // PC wrap at top of address space.
    drive(1'b0, 32'h0, 1'b1, 32'h0093_4501, 32'hFFFF_FFFC, 1'b1);
    #1 chk_out("wrap_0", 1'b1, 32'h0000_4501, 32'hFFFF_FFFC, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1 chk_out("wrap_empty", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1);
    #1 chk_out("wrap_str", 1'b1, 32'h0000_0093, 32'hFFFF_FFFE, 1'b1, 1'b1);
    @(negedge clk);

    // Reset mid-stream with a pending RVC halfword discards it.
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1 chk_out("pend", 1'b1, 32'h0000_0000, 32'h0000_0002, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1 chk_out("rst_mid", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_out("rst_after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
